// File: rtl/data_memory_stage_if.sv
// Execute-to-memory and memory-to-writeback signal bundle for the DM stage.
// The execute side drives the master modport and the DM stage uses the slave modport.
interface data_memory_stage_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] b_ex;
  logic              valid_ex;
  logic              mem_rd_ex;
  logic              mem_wr_ex;
  logic [2:0]        rd_ex;
  logic              wr_en_ex;
  logic [DATA_W-1:0] mux_ans_dm;
  logic              valid_dm;
  logic [2:0]        rd_dm;
  logic              wr_en_dm;
  logic              stall_dm;

  modport master (
    output ans_ex, b_ex, valid_ex, mem_rd_ex, mem_wr_ex, rd_ex, wr_en_ex,
    input  mux_ans_dm, valid_dm, rd_dm, wr_en_dm, stall_dm
  );

  modport slave (
    input  ans_ex, b_ex, valid_ex, mem_rd_ex, mem_wr_ex, rd_ex, wr_en_ex,
    output mux_ans_dm, valid_dm, rd_dm, wr_en_dm, stall_dm
  );
endinterface

// File: rtl/data_memory_stage.sv
// Memory-access stage: byte-wide data memory with one-cycle stores and two-cycle loads.
// The load-stall flag is decoded from the FSM state alone, so it has no path from the inputs.
module data_memory_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_stage_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic                mem_we_s;
  logic [DATA_W-1:0]   loaddata_r;
  logic [DATA_W-1:0]   loaddata_nxt_s;
  logic                ld_wr_en_r;
  logic                ld_wr_en_nxt_s;
  logic [DATA_W-1:0]   mux_ans_r;
  logic [DATA_W-1:0]   mux_ans_nxt_s;
  logic                valid_r;
  logic                valid_nxt_s;
  logic [2:0]          rd_r;
  logic [2:0]          rd_nxt_s;
  logic                wr_en_r;
  logic                wr_en_nxt_s;

  // Upper address bits are dropped, so addresses wrap around the memory.
  assign addr_s = bus.ans_ex[ADDR_W-1:0];

  // Next-state and next-output decode; a store wins over a load when both are flagged.
  always_comb begin
    state_nxt_s    = state_r;
    mem_we_s       = 1'b0;
    loaddata_nxt_s = loaddata_r;
    ld_wr_en_nxt_s = ld_wr_en_r;
    mux_ans_nxt_s  = mux_ans_r;
    rd_nxt_s       = rd_r;
    valid_nxt_s    = 1'b0;
    wr_en_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.valid_ex) begin
          if (bus.mem_wr_ex) begin
            mem_we_s      = 1'b1;
            mux_ans_nxt_s = bus.ans_ex;
            valid_nxt_s   = 1'b1;
            rd_nxt_s      = bus.rd_ex;
          end else if (bus.mem_rd_ex) begin
            loaddata_nxt_s = mem_r[addr_s];
            ld_wr_en_nxt_s = bus.wr_en_ex;
            rd_nxt_s       = bus.rd_ex;
            state_nxt_s    = ST_LOAD;
          end else begin
            mux_ans_nxt_s = bus.ans_ex;
            valid_nxt_s   = 1'b1;
            rd_nxt_s      = bus.rd_ex;
            wr_en_nxt_s   = bus.wr_en_ex;
          end
        end else begin
          valid_nxt_s = 1'b0;
          wr_en_nxt_s = 1'b0;
        end
      end
      ST_LOAD: begin
        mux_ans_nxt_s = loaddata_r;
        valid_nxt_s   = 1'b1;
        wr_en_nxt_s   = ld_wr_en_r;
        state_nxt_s   = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output and load-capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaddata_r <= '0;
      ld_wr_en_r <= 1'b0;
      mux_ans_r  <= '0;
      valid_r    <= 1'b0;
      rd_r       <= 3'd0;
      wr_en_r    <= 1'b0;
    end else begin
      loaddata_r <= loaddata_nxt_s;
      ld_wr_en_r <= ld_wr_en_nxt_s;
      mux_ans_r  <= mux_ans_nxt_s;
      valid_r    <= valid_nxt_s;
      rd_r       <= rd_nxt_s;
      wr_en_r    <= wr_en_nxt_s;
    end
  end

  // Data memory; cleared on reset, and the write lands before any later load can read it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_r[addr_s] <= bus.b_ex;
    end else begin
      mem_r[addr_s] <= mem_r[addr_s];
    end
  end

  assign bus.mux_ans_dm = mux_ans_r;
  assign bus.valid_dm   = valid_r;
  assign bus.rd_dm      = rd_r;
  assign bus.wr_en_dm   = wr_en_r;
  assign bus.stall_dm   = (state_r == ST_LOAD);
endmodule

// File: tb/tb_data_memory_stage.sv
// Directed and randomized checks of the DM stage against an instruction-level model
// that keeps a plain byte array for memory and the last visible result/destination.
module tb_data_memory_stage;
  localparam int K_BUBBLE = 0;
  localparam int K_ALU    = 1;
  localparam int K_STORE  = 2;
  localparam int K_LOAD   = 3;
  localparam int K_BOTH   = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [7:0] mdl_mem [32];
  logic [7:0] exp_mux;
  logic [2:0] exp_rd;

  data_memory_stage_if #(.DATA_W(8)) bus ();

  data_memory_stage #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [7:0] ans, input logic [7:0] b,
                       input logic [2:0] rdi, input logic we);
    bus.valid_ex  = v;
    bus.mem_rd_ex = rd;
    bus.mem_wr_ex = wr;
    bus.ans_ex    = ans;
    bus.b_ex      = b;
    bus.rd_ex     = rdi;
    bus.wr_en_ex  = we;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_mem[i] = 8'h00;
    exp_mux = 8'h00;
    exp_rd  = 3'd0;
  endtask

  // Presents one instruction, lets it complete, and checks what write-back sees.
  task automatic issue(input int kind, input logic [7:0] ans, input logic [7:0] b,
                       input logic [2:0] rdi, input logic we);
    int a;
    a = int'(ans) % 32;
    case (kind)
      K_BUBBLE: drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), ans, b, rdi, we);
      K_ALU:    drive(1'b1, 1'b0, 1'b0, ans, b, rdi, we);
      K_STORE:  drive(1'b1, 1'b0, 1'b1, ans, b, rdi, we);
      K_LOAD:   drive(1'b1, 1'b1, 1'b0, ans, b, rdi, we);
      default:  drive(1'b1, 1'b1, 1'b1, ans, b, rdi, we);
    endcase
    @(posedge clk);
    #1;
    if (kind == K_BUBBLE) begin
      chk("bubble_valid", {7'd0, bus.valid_dm}, 8'h00);
      chk("bubble_wren",  {7'd0, bus.wr_en_dm}, 8'h00);
      chk("bubble_mux",   bus.mux_ans_dm, exp_mux);
      chk("bubble_rd",    {5'd0, bus.rd_dm}, {5'd0, exp_rd});
      chk("bubble_stall", {7'd0, bus.stall_dm}, 8'h00);
    end else if (kind == K_ALU) begin
      exp_mux = ans;
      exp_rd  = rdi;
      chk("alu_valid", {7'd0, bus.valid_dm}, 8'h01);
      chk("alu_mux",   bus.mux_ans_dm, exp_mux);
      chk("alu_rd",    {5'd0, bus.rd_dm}, {5'd0, exp_rd});
      chk("alu_wren",  {7'd0, bus.wr_en_dm}, {7'd0, we});
      chk("alu_stall", {7'd0, bus.stall_dm}, 8'h00);
    end else if (kind == K_LOAD) begin
      exp_rd = rdi;
      chk("ld1_stall", {7'd0, bus.stall_dm}, 8'h01);
      chk("ld1_valid", {7'd0, bus.valid_dm}, 8'h00);
      chk("ld1_wren",  {7'd0, bus.wr_en_dm}, 8'h00);
      chk("ld1_mux",   bus.mux_ans_dm, exp_mux);
      // Anything driven during the stall cycle must be ignored, including stores.
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 1));
      @(posedge clk);
      #1;
      exp_mux = mdl_mem[a];
      chk("ld2_valid", {7'd0, bus.valid_dm}, 8'h01);
      chk("ld2_mux",   bus.mux_ans_dm, exp_mux);
      chk("ld2_rd",    {5'd0, bus.rd_dm}, {5'd0, exp_rd});
      chk("ld2_wren",  {7'd0, bus.wr_en_dm}, {7'd0, we});
      chk("ld2_stall", {7'd0, bus.stall_dm}, 8'h00);
    end else begin
      mdl_mem[a] = b;
      exp_mux    = ans;
      exp_rd     = rdi;
      chk("st_valid", {7'd0, bus.valid_dm}, 8'h01);
      chk("st_mux",   bus.mux_ans_dm, exp_mux);
      chk("st_rd",    {5'd0, bus.rd_dm}, {5'd0, exp_rd});
      chk("st_wren",  {7'd0, bus.wr_en_dm}, 8'h00);
      chk("st_stall", {7'd0, bus.stall_dm}, 8'h00);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mux"},   bus.mux_ans_dm, 8'h00);
    chk({tag, "_valid"}, {7'd0, bus.valid_dm}, 8'h00);
    chk({tag, "_rd"},    {5'd0, bus.rd_dm}, 8'h00);
    chk({tag, "_wren"},  {7'd0, bus.wr_en_dm}, 8'h00);
    chk({tag, "_stall"}, {7'd0, bus.stall_dm}, 8'h00);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    reset = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    issue(K_LOAD, 8'h07, 8'h00, 3'd1, 1'b1);
    issue(K_ALU, 8'h3C, 8'h00, 3'd2, 1'b1);
    issue(K_BUBBLE, 8'h99, 8'h42, 3'd6, 1'b1);
    issue(K_STORE, 8'h04, 8'hA5, 3'd3, 1'b1);
    issue(K_LOAD, 8'h04, 8'h00, 3'd5, 1'b1);
    issue(K_ALU, 8'h11, 8'h00, 3'd4, 1'b1);
    issue(K_STORE, 8'h25, 8'h5A, 3'd7, 1'b1);
    issue(K_LOAD, 8'h05, 8'h00, 3'd2, 1'b0);
    issue(K_BOTH, 8'h0C, 8'hC3, 3'd1, 1'b1);
    issue(K_LOAD, 8'hEC, 8'h00, 3'd6, 1'b1);

    for (int i = 0; i < 120; i++) begin
      issue($urandom_range(0, 4), 8'($urandom), 8'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)));
    end

    issue(K_STORE, 8'h0A, 8'h77, 3'd3, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 8'h0A, 8'h00, 3'd5, 1'b1);
    @(posedge clk);
    #1;
    chk("midload_stall", {7'd0, bus.stall_dm}, 8'h01);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk_reset_outputs("midload");
    @(negedge clk);
    reset = 1'b1;
    issue(K_LOAD, 8'h0A, 8'h00, 3'd5, 1'b1);
    issue(K_LOAD, 8'h04, 8'h00, 3'd4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
Memory-access (DM) stage of the 8-bit pipelined processor, sitting between execute and write-back. It holds a small byte-wide data memory, performs loads and stores addressed by the ALU result, and registers the selected result (ALU answer or loaded byte) onto mux_ans_dm, which feeds the write-back stage. Loads take two cycles. The stage stalls upstream during the second load cycle using a Moore-style stall output.

Parameters:
ADDR_W, 5, data memory address width; the memory holds 2**ADDR_W bytes.
DATA_W, 8, datapath width. The design is fixed at 8; the parameter exists for documentation only.

Ports:
clk  input  1  stage clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
ans_ex  input  8  ALU result from execute; also the memory address.
b_ex  input  8  store data from execute.
valid_ex  input  1  execute stage presents a real instruction.
mem_rd_ex  input  1  instruction is a load.
mem_wr_ex  input  1  instruction is a store.
rd_ex  input  3  destination register index.
wr_en_ex  input  1  instruction writes the register file.
mux_ans_dm  output  8  registered result to write-back.
valid_dm  output  1  mux_ans_dm carries a completed instruction this cycle.
rd_dm  output  3  registered destination index.
wr_en_dm  output  1  registered register-file write enable.
stall_dm  output  1  upstream must hold its outputs this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - mux_ans_dm=0, valid_dm=0, rd_dm=0, wr_en_dm=0, stall_dm=0.
  - FSM goes to IDLE.
  - All memory bytes are cleared to 0.
  - The internal load-data register is cleared to 0.
- Address: addr = ans_ex[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo 2**ADDR_W.
- FSM states: IDLE and LOAD. stall_dm = (state==LOAD), decoded from state only; it has no combinational path from the inputs.
- IDLE, valid_ex=0 (bubble):
  - valid_dm<=0, wr_en_dm<=0.
  - mux_ans_dm and rd_dm hold their values.
  - No memory write.
- IDLE, valid_ex=1, mem_wr_ex=1 (store; takes priority even if mem_rd_ex=1):
  - mem[addr]<=b_ex at the edge.
  - mux_ans_dm<=ans_ex, valid_dm<=1, rd_dm<=rd_ex, wr_en_dm<=0.
  - Latency 1. No stall.
- IDLE, valid_ex=1, mem_rd_ex=1, mem_wr_ex=0 (load):
  - Edge 1: loaddata<=mem[addr], rd_dm<=rd_ex, valid_dm<=0, wr_en_dm<=0, state<=LOAD.
  - Edge 2 (in LOAD): mux_ans_dm<=loaddata, valid_dm<=1, wr_en_dm<=wr_en_ex as captured at edge 1, state<=IDLE.
  - Total latency 2. Sustained throughput is one load per 2 cycles.
- IDLE, valid_ex=1, no memory operation (ALU op):
  - mux_ans_dm<=ans_ex, valid_dm<=1, rd_dm<=rd_ex, wr_en_dm<=wr_en_ex.
  - Latency 1.
- LOAD: all inputs are ignored. Upstream holds the following instruction while stall_dm=1, and that instruction is accepted at the first edge after returning to IDLE.
- Read-after-write: a load that follows a store to the same address returns the stored byte. The write completes at the earlier edge, so no bypass is needed.
- Reset asserted mid-load: the operation is abandoned, all state returns to reset values, and memory is cleared.
- No arithmetic in this stage; all data is passed at full 8-bit width.

Test Plan:
- Reset: hold reset=0 → all outputs 0 and stall_dm=0. Release, then load from address 7 → mux_ans_dm=0x00.
- ALU pass-through: valid_ex=1, ans_ex=0x3C, rd_ex=2, wr_en_ex=1, no mem op → next cycle mux_ans_dm=0x3C, valid_dm=1, rd_dm=2, wr_en_dm=1, stall_dm=0.
- Store then load: store b_ex=0xA5 at ans_ex=0x04, then load from ans_ex=0x04 with rd_ex=5 →
  - Cycle after the load edge: stall_dm=1, valid_dm=0.
  - Following cycle: mux_ans_dm=0xA5, valid_dm=1, rd_dm=5, wr_en_dm=1, stall_dm=0.
  - An ALU op presented during the stall (ans_ex=0x11) emerges one cycle after the load result.
- Address wrap and priority:
  - Store 0x5A at ans_ex=0x25 → mem[5]=0x5A; a load from 0x05 returns 0x5A.
  - valid_ex=1 with mem_rd_ex=mem_wr_ex=1 → performs a store only: wr_en_dm=0, no stall.
- Bubble: valid_ex=0 after an ALU op that produced 0x3C → valid_dm=0, wr_en_dm=0, mux_ans_dm stays 0x3C, memory unchanged.
- Reset mid-load: assert reset=0 while state=LOAD → outputs go to 0 immediately (before the next edge), stall_dm=0, and a later load of the previously stored address returns 0x00.
